floating_addsub_fsm: RTL and testbench
======================================

FLOATING_ADDSUB_FSM -- requirements
Module: floating_addsub_fsm

Interface
REQ-001 SHALL have parameter EXPONENT, default 8, exponent field width (3..11).
REQ-002 SHALL have parameter FRACTION, default 23, stored fraction width (4..52); WIDTH = 1+EXPONENT+FRACTION, bias = 2^(EXPONENT-1)-1.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, operation request; sampled only while ready=1.
REQ-006 SHALL have port numA, input, WIDTH, operand A {sign, exp, frac}.
REQ-007 SHALL have port numB, input, WIDTH, operand B.
REQ-008 SHALL have port operation, input, 1, 0=A+B, 1=A-B.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-011 SHALL have port result, output, WIDTH, rounded sum; held until the next accepted start.
REQ-012 SHALL have ports overflow, underflow, invalid, inexact, output, 1 each, exception flags; valid with done, held with result.

Function
REQ-013 SHALL capture numA, numB, operation on the edge where start=1 and ready=1; input changes after capture have no effect.
REQ-014 SHALL ignore start while ready=0; no queueing.
REQ-015 FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE; DONE always returns to IDLE next edge.
REQ-016 IDLE->ALIGN on accepted start; ALIGN->ADD; ADD->NORM; NORM->ROUND once hidden bit is in place; ROUND->DONE, or ROUND->NORM once if rounding carried out of the significand.
REQ-017 ALIGN: operand with smaller exponent (tie: B) is right-shifted by |expA-expB| in one cycle into a significand with hidden bit and guard, round, sticky bits (FRACTION+4 bits); all shifted-out ones OR into sticky.
REQ-018 Exponent difference >= FRACTION+3 SHALL reduce the smaller operand to sticky only.
REQ-019 ADD: effective subtract when signA XOR signB XOR operation = 1; magnitude subtraction is larger minus smaller; result sign = sign of larger-magnitude operand (B sign inverted when operation=1).
REQ-020 NORM: carry-out -> one right shift (sticky preserved), exponent+1, 1 cycle; otherwise one left shift per cycle, exponent-1 each, until hidden bit set; already normalized -> 1 cycle.
REQ-021 ROUND: round-to-nearest-even on guard/round/sticky; inexact=1 if any of them nonzero.
REQ-022 Exact zero from ADD SHALL skip NORM/ROUND left shifting, yield +0 (0x0 pattern), go NORM->ROUND->DONE with no flags.
REQ-023 Exponent reaching all-ones after NORM/ROUND SHALL give signed infinity, overflow=1, inexact=1.
REQ-024 Exponent falling below 1 during NORM SHALL stop shifting and give signed zero, underflow=1, inexact=1 (subnormals flushed).
REQ-025 Subnormal inputs (exp=0) SHALL be treated as signed zero.
REQ-026 Specials resolved in ALIGN, going directly ALIGN->DONE: any NaN input, or inf-inf effective subtract -> 0 sign, exp all-ones, frac MSB only, invalid=1 on inf-inf; single inf -> that inf; inf+inf same sign -> that inf.
REQ-027 Normal-path latency: start sampled at edge k -> done=1 after edge k+4 + (NORM cycles-1) + (2 if round-carry re-normalization).

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, ready=1, done=0, result=0, all flags 0, regardless of state, including mid-operation.
REQ-029 Operation in flight at reset SHALL be discarded with no done pulse.

Verification
REQ-030 EXPONENT=8/FRACTION=23: A=0x3F800000, B=0x3F800000, op=0, start at edge k -> done after edge k+4, result=0x40000000, flags 0.
REQ-031 A=0x3F800000, B=0x3F400000, op=1 -> two NORM cycles, done after edge k+5, result=0x3E800000, flags 0.
REQ-032 A=0x7F7FFFFF, B=0x7F7FFFFF, op=0 -> result=0x7F800000, overflow=1, inexact=1.
REQ-033 A=0x7F800000, B=0x7F800000, op=1 -> ALIGN->DONE, result=0x7FC00000, invalid=1; A=0x3F800000, B=0x33800000, op=0 -> result=0x3F800000, inexact=1 (tie to even).
REQ-034 start during NORM ignored; rst_n=0 in ADD -> next cycle ready=1, done=0, result=0, no done pulse follows.

Source files
------------

// File: rtl/floating_addsub_fsm.sv
// Multi-cycle floating-point adder/subtractor for a parameterized format.
// The FSM walks through alignment, addition, normalization and rounding.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// ALIGN | unpack operands, resolve specials, right-shift the smaller operand
// ADD   | add or subtract the aligned significands
// NORM  | one normalization shift per cycle until the hidden bit is in place
// ROUND | round-to-nearest-even, detect overflow/underflow, write result
// DONE  | one-cycle done pulse
module floating_addsub_fsm #(
    parameter int EXPONENT = 8,
    parameter int FRACTION = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [EXPONENT+FRACTION:0]   numA,
    input  logic [EXPONENT+FRACTION:0]   numB,
    input  logic                         operation,
    output logic                         ready,
    output logic                         done,
    output logic [EXPONENT+FRACTION:0]   result,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         invalid,
    output logic                         inexact
);
    localparam int WIDTH = 1 + EXPONENT + FRACTION;
    localparam int SIG   = FRACTION + 4;   // hidden, fraction, guard, round, sticky
    localparam int SUMW  = FRACTION + 5;   // SIG plus carry
    localparam logic [EXPONENT-1:0] EXP_ONES = {EXPONENT{1'b1}};
    localparam logic [EXPONENT-1:0] EXP_ONE  = {{(EXPONENT-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
    state_t r_state, w_next;

    logic [WIDTH-1:0]    r_a, r_b;
    logic                r_op;
    logic [SIG-1:0]      r_sig_big, r_sig_small;
    logic [EXPONENT-1:0] r_exp;
    logic                r_sign_big, r_sign_small, r_sign;
    logic [SUMW-1:0]     r_sum;
    logic                r_uf, r_inx;

    // operand unpacking; B's sign is folded with the operation
    logic                w_sign_a, w_sign_b;
    logic [EXPONENT-1:0] w_exp_a, w_exp_b;
    logic [FRACTION-1:0] w_frac_a, w_frac_b;
    logic                w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic [SIG-1:0]      w_sig_a, w_sig_b;

    assign w_sign_a = r_a[WIDTH-1];
    assign w_sign_b = r_b[WIDTH-1] ^ r_op;
    assign w_exp_a  = r_a[WIDTH-2:FRACTION];
    assign w_exp_b  = r_b[WIDTH-2:FRACTION];
    assign w_frac_a = r_a[FRACTION-1:0];
    assign w_frac_b = r_b[FRACTION-1:0];
    assign w_zero_a = (w_exp_a == '0);
    assign w_zero_b = (w_exp_b == '0);
    assign w_inf_a  = (w_exp_a == EXP_ONES) && (w_frac_a == '0);
    assign w_inf_b  = (w_exp_b == EXP_ONES) && (w_frac_b == '0);
    assign w_nan_a  = (w_exp_a == EXP_ONES) && (w_frac_a != '0);
    assign w_nan_b  = (w_exp_b == EXP_ONES) && (w_frac_b != '0);
    // subnormals are flushed to zero by dropping the whole significand
    assign w_sig_a  = w_zero_a ? '0 : {1'b1, w_frac_a, 3'b000};
    assign w_sig_b  = w_zero_b ? '0 : {1'b1, w_frac_b, 3'b000};

    // specials
    logic             w_any_nan, w_inf_inf_sub, w_special;
    logic [WIDTH-1:0] w_special_res;

    assign w_any_nan     = w_nan_a | w_nan_b;
    assign w_inf_inf_sub = w_inf_a & w_inf_b & (w_sign_a ^ w_sign_b);
    assign w_special     = w_any_nan | w_inf_a | w_inf_b;
    assign w_special_res = (w_any_nan | w_inf_inf_sub) ? {1'b0, EXP_ONES, 1'b1, {(FRACTION-1){1'b0}}} :
                           w_inf_a ? {w_sign_a, EXP_ONES, {FRACTION{1'b0}}} :
                                     {w_sign_b, EXP_ONES, {FRACTION{1'b0}}};

    // alignment: on an exponent tie B is the one shifted
    logic                w_a_big;
    logic [EXPONENT-1:0] w_exp_big, w_exp_small, w_diff;
    logic [SIG-1:0]      w_sig_big, w_sig_small, w_shifted, w_mask, w_aligned;
    logic [31:0]         w_diff_wide;
    logic                w_far, w_lost;

    assign w_a_big     = (w_exp_a >= w_exp_b);
    assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
    assign w_sig_big   = w_a_big ? w_sig_a : w_sig_b;
    assign w_sig_small = w_a_big ? w_sig_b : w_sig_a;
    assign w_diff      = w_exp_big - w_exp_small;
    assign w_diff_wide = 32'(w_diff);
    assign w_far       = (w_diff_wide >= 32'(FRACTION + 3));
    assign w_shifted   = w_sig_small >> w_diff;
    assign w_mask      = ~({SIG{1'b1}} << w_diff);
    assign w_lost      = |(w_sig_small & w_mask);
    assign w_aligned   = w_far ? {{(SIG-1){1'b0}}, |w_sig_small}
                               : {w_shifted[SIG-1:1], w_shifted[0] | w_lost};

    // add/subtract
    logic            w_eff_sub, w_mag_ge;
    logic [SUMW-1:0] w_ext_big, w_ext_small;

    assign w_eff_sub   = r_sign_big ^ r_sign_small;
    assign w_mag_ge    = (r_sig_big >= r_sig_small);
    assign w_ext_big   = {1'b0, r_sig_big};
    assign w_ext_small = {1'b0, r_sig_small};

    // normalization
    logic            w_carry, w_hidden, w_sum_zero, w_exp_low;
    logic [SUMW-1:0] w_shl;

    assign w_carry    = r_sum[SUMW-1];
    assign w_hidden   = r_sum[SUMW-2];
    assign w_sum_zero = (r_sum == '0);
    assign w_exp_low  = (r_exp <= EXP_ONE);
    assign w_shl      = {r_sum[SUMW-2:0], 1'b0};

    // rounding
    logic                w_g, w_r, w_s, w_rup, w_rnd_carry, w_exp_ovf;
    logic [FRACTION+1:0] w_rounded;

    assign w_g         = r_sum[2];
    assign w_r         = r_sum[1];
    assign w_s         = r_sum[0];
    assign w_rup       = w_g & (w_r | w_s | r_sum[3]);
    assign w_rounded   = {1'b0, r_sum[SUMW-2:3]} + {{(FRACTION+1){1'b0}}, w_rup};
    assign w_rnd_carry = w_rounded[FRACTION+1];
    assign w_exp_ovf   = (r_exp == EXP_ONES);

    assign ready = (r_state == S_IDLE);
    assign done  = (r_state == S_DONE);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ALIGN;
            S_ALIGN: w_next = w_special ? S_DONE : S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM: begin
                if (w_sum_zero || w_carry || w_hidden || w_exp_low || w_shl[SUMW-2])
                    w_next = S_ROUND;
            end
            S_ROUND: begin
                if (!w_sum_zero && !r_uf && !w_exp_ovf && w_rnd_carry) w_next = S_NORM;
                else                                                   w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0; r_b <= '0; r_op <= 1'b0;
            r_sig_big <= '0; r_sig_small <= '0; r_exp <= '0;
            r_sign_big <= 1'b0; r_sign_small <= 1'b0; r_sign <= 1'b0;
            r_sum <= '0; r_uf <= 1'b0; r_inx <= 1'b0;
            result <= '0; overflow <= 1'b0; underflow <= 1'b0;
            invalid <= 1'b0; inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a  <= numA;
                        r_b  <= numB;
                        r_op <= operation;
                    end
                end
                S_ALIGN: begin
                    r_uf  <= 1'b0;
                    r_inx <= 1'b0;
                    if (w_special) begin
                        result    <= w_special_res;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        invalid   <= w_inf_inf_sub & ~w_any_nan;
                        inexact   <= 1'b0;
                    end else begin
                        r_sig_big    <= w_sig_big;
                        r_sig_small  <= w_aligned;
                        r_exp        <= w_exp_big;
                        r_sign_big   <= w_a_big ? w_sign_a : w_sign_b;
                        r_sign_small <= w_a_big ? w_sign_b : w_sign_a;
                    end
                end
                S_ADD: begin
                    if (!w_eff_sub) begin
                        r_sum  <= w_ext_big + w_ext_small;
                        r_sign <= r_sign_big;
                    end else if (w_mag_ge) begin
                        r_sum  <= w_ext_big - w_ext_small;
                        r_sign <= r_sign_big;
                    end else begin
                        r_sum  <= w_ext_small - w_ext_big;
                        r_sign <= r_sign_small;
                    end
                end
                S_NORM: begin
                    if (w_sum_zero) begin
                        r_sum <= r_sum;
                    end else if (w_carry) begin
                        r_sum <= {1'b0, r_sum[SUMW-1:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + EXP_ONE;
                    end else if (w_hidden) begin
                        r_sum <= r_sum;
                    end else if (w_exp_low) begin
                        r_uf <= 1'b1;
                    end else begin
                        r_sum <= w_shl;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                S_ROUND: begin
                    if (w_sum_zero) begin
                        result <= '0;
                        overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
                    end else if (r_uf) begin
                        result <= {r_sign, {(WIDTH-1){1'b0}}};
                        overflow <= 1'b0; underflow <= 1'b1; invalid <= 1'b0; inexact <= 1'b1;
                    end else if (w_exp_ovf) begin
                        result <= {r_sign, EXP_ONES, {FRACTION{1'b0}}};
                        overflow <= 1'b1; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b1;
                    end else if (w_rnd_carry) begin
                        r_sum <= {w_rounded, 3'b000};
                        r_inx <= r_inx | w_g | w_r | w_s;
                    end else begin
                        result <= {r_sign, r_exp, w_rounded[FRACTION-1:0]};
                        overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0;
                        inexact <= r_inx | w_g | w_r | w_s;
                    end
                end
                default: r_sum <= r_sum;
            endcase
        end
    end
endmodule

// File: tb/tb_floating_addsub_fsm.sv
// Bench for floating_addsub_fsm (single precision): directed vectors with
// hand-computed results, scoreboard queue drained by a done-driven monitor.
module tb_floating_addsub_fsm;
    localparam int NV = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        operation = 1'b0;
    logic [31:0] numA = '0;
    logic [31:0] numB = '0;
    logic        ready, done, overflow, underflow, invalid, inexact;
    logic [31:0] result;

    floating_addsub_fsm #(.EXPONENT(8), .FRACTION(23)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .numA(numA), .numB(numB),
        .operation(operation), .ready(ready), .done(done), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;   // {overflow, underflow, invalid, inexact}
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // directed vectors: A, B, op, result, flags, done latency in edges after acceptance
    logic [31:0] tv_a   [NV] = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                                 32'h3FFFFFFF, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800001,
                                 32'h7F800001, 32'h7F800000, 32'h00000005};
    logic [31:0] tv_b   [NV] = '{32'h3F800000, 32'h3F400000, 32'h7F7FFFFF, 32'h7F800000, 32'h33800000,
                                 32'h33800000, 32'h3F800000, 32'h40000000, 32'h00800000, 32'h00800000,
                                 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic        tv_op  [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] tv_res [NV] = '{32'h40000000, 32'h3E800000, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
                                 32'h40000000, 32'h00000000, 32'hBF800000, 32'h3F800000, 32'h00000000,
                                 32'h7FC00000, 32'h7F800000, 32'h3F800000};
    logic [3:0]  tv_fl  [NV] = '{4'b0000, 4'b0000, 4'b1001, 4'b0010, 4'b0001,
                                 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0101,
                                 4'b0000, 4'b0000, 4'b0000};
    int          tv_lat [NV] = '{4, 5, 4, 1, 4, 6, 4, 4, 4, 4, 1, 1, 4};

    // issue one operation from a negedge; scrambles inputs after capture
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] res, input logic [3:0] fl, input int lat,
                         input bit expect_it);
        exp_t e;
        int   t;
        t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            check("ready_wait", {31'b0, ready}, 32'd1);
            return;
        end
        numA = a; numB = b; operation = op; start = 1'b1;
        if (expect_it) begin
            e.res = res; e.flags = fl; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        numA = 32'hDEADBEEF; numB = 32'h12345678; operation = ~op;
    endtask

    // monitor: compares whenever done is presented, and flags any unexpected done
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else if (done) begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("flags", {28'b0, overflow, underflow, invalid, inexact}, {28'b0, e.flags});
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_flags", {28'b0, overflow, underflow, invalid, inexact}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            issue(tv_a[i], tv_b[i], tv_op[i], tv_res[i], tv_fl[i], tv_lat[i], 1'b1);

        // start while the FSM sits in NORM must be ignored
        issue(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000, 5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        numA = 32'h40400000; numB = 32'h40400000; operation = 1'b0; start = 1'b1;
        check("ready_in_norm", {31'b0, ready}, 32'd0);
        @(negedge clk);
        start = 1'b0;

        // reset while in ADD discards the operation
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 4'b0000, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midop_reset_ready", {31'b0, ready}, 32'd1);
        check("midop_reset_done", {31'b0, done}, 32'd0);
        check("midop_reset_result", result, 32'h0);
        check("midop_reset_flags", {28'b0, overflow, underflow, invalid, inexact}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // one more operation after the aborted one
        issue(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 4, 1'b1);

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
